seq_cmp_ctrl: RTL and testbench



---
 rtl/seq_cmp_ctrl.sv | 114 +++++++++++
 tb/tb_seq_cmp_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_cmp_ctrl.sv
// Multi-cycle unsigned magnitude comparator: walks a shared 4-bit comparator
// over the operand slices, most-significant first, stopping at the first unequal slice.

module cmp4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       eq_c,
   output logic       gt_c,
   output logic       lt_c
);
   always_comb begin
      eq_c = (a == b);
      gt_c = (a > b);
      lt_c = (a < b);
   end
endmodule

module seq_cmp_ctrl #(
   parameter int unsigned WIDTH = 16
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [WIDTH-1:0]                    a,
   input  logic [WIDTH-1:0]                    b,
   output logic                                busy,
   output logic                                done,
   output logic                                equal,
   output logic                                more,
   output logic                                less,
   output logic [$clog2(WIDTH/4):0]            slices
);
   localparam int unsigned NSLICE = WIDTH / 4;
   localparam int unsigned IW     = $clog2(NSLICE);
   localparam int unsigned SW     = $clog2(NSLICE) + 1;

   if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
      $error("seq_cmp_ctrl: WIDTH must be a multiple of 4 and at least 8");
   end

   typedef enum logic {IDLE, CMP} state_t;

   state_t           state;
   logic [WIDTH-1:0] ra, rb;
   logic [IW-1:0]    idx;
   logic [3:0]       sa_c, sb_c;
   logic             eq_c, gt_c, lt_c;

   // Current slice selected by idx from the latched operands
   always_comb begin
      sa_c = 4'(ra >> (32'(idx) * 4));
      sb_c = 4'(rb >> (32'(idx) * 4));
   end

   cmp4bit u_cmp (
      .a    (sa_c),
      .b    (sb_c),
      .eq_c (eq_c),
      .gt_c (gt_c),
      .lt_c (lt_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         ra     <= '0;
         rb     <= '0;
         idx    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         equal  <= 1'b0;
         more   <= 1'b0;
         less   <= 1'b0;
         slices <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  ra     <= a;
                  rb     <= b;
                  idx    <= IW'(NSLICE - 1);
                  equal  <= 1'b0;
                  more   <= 1'b0;
                  less   <= 1'b0;
                  slices <= '0;
                  busy   <= 1'b1;
                  state  <= CMP;
               end
            end
            CMP: begin
               // First unequal slice decides; all-equal finishes at slice 0
               if (!eq_c) begin
                  more   <= gt_c;
                  less   <= lt_c;
                  slices <= SW'(NSLICE - 32'(idx));
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end else if (idx == '0) begin
                  equal  <= 1'b1;
                  slices <= SW'(NSLICE);
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_cmp_ctrl.sv
// Scoreboard bench for seq_cmp_ctrl: directed 16-bit vectors plus 8/32-bit sweeps.
`timescale 1ns/1ps
module tb_seq_cmp_ctrl;
   typedef struct {
      logic eq;
      logic mo;
      logic le;
      int   sl;
      int   acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   logic        start16 = 1'b0, busy16, done16, eq16, mo16, le16;
   logic [15:0] a16 = '0, b16 = '0;
   logic [2:0]  sl16;
   logic        start8 = 1'b0, busy8, done8, eq8, mo8, le8;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [1:0]  sl8;
   logic        start32 = 1'b0, busy32, done32, eq32, mo32, le32;
   logic [31:0] a32 = '0, b32 = '0;
   logic [3:0]  sl32;

   exp_t q16[$];
   exp_t q8[$];
   exp_t q32[$];
   logic pd16 = 1'b0, pd8 = 1'b0, pd32 = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_cmp_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
      .busy(busy16), .done(done16), .equal(eq16), .more(mo16), .less(le16), .slices(sl16));
   seq_cmp_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .equal(eq8), .more(mo8), .less(le8), .slices(sl8));
   seq_cmp_ctrl #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
      .busy(busy32), .done(done32), .equal(eq32), .more(mo32), .less(le32), .slices(sl32));

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic score(input string tag, input exp_t e, input logic eq, input logic mo,
                        input logic le, input int sl);
      chk({tag, " equal"}, int'(eq), int'(e.eq));
      chk({tag, " more"}, int'(mo), int'(e.mo));
      chk({tag, " less"}, int'(le), int'(e.le));
      chk({tag, " onehot"}, int'(eq) + int'(mo) + int'(le), 1);
      chk({tag, " slices"}, sl, e.sl);
      chk({tag, " latency"}, cyc - e.acc, e.sl);
   endtask

   task automatic unexpected(input string tag);
      checks++;
      failures++;
      $display("FAIL %s: done pulse with no pending request (cycle %0d)", tag, cyc);
   endtask

   // Monitors: pop the oldest expectation whenever a DUT presents done
   always @(negedge clk) begin
      if (!rst) begin
         if (done16) begin
            if (q16.size() == 0) unexpected("w16");
            else score("w16", q16.pop_front(), eq16, mo16, le16, int'(sl16));
         end
         if (pd16) chk("w16 done width", int'(done16), 0);
         if (done8) begin
            if (q8.size() == 0) unexpected("w8");
            else score("w8", q8.pop_front(), eq8, mo8, le8, int'(sl8));
         end
         if (pd8) chk("w8 done width", int'(done8), 0);
         if (done32) begin
            if (q32.size() == 0) unexpected("w32");
            else score("w32", q32.pop_front(), eq32, mo32, le32, int'(sl32));
         end
         if (pd32) chk("w32 done width", int'(done32), 0);
      end
      pd16 = done16;
      pd8  = done8;
      pd32 = done32;
   end

   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input int nsl);
      exp_t m;
      int   cnt = 0;
      bit   stop = 0;
      for (int i = nsl - 1; i >= 0; i--) begin
         if (!stop && ((x >> (4 * i)) & 32'hF) == ((y >> (4 * i)) & 32'hF)) cnt++;
         else stop = 1;
      end
      m.sl  = (cnt + 1 > nsl) ? nsl : cnt + 1;
      m.eq  = (x == y);
      m.mo  = (x > y);
      m.le  = (x < y);
      m.acc = 0;
      return m;
   endfunction

   // Wait (bounded) until dut16 signals done; sample #1 after each edge
   task automatic wait_done16(input string nm, output int busy_cycles);
      bit seen = 0;
      busy_cycles = int'(busy16);
      for (int t = 0; t < 20 && !seen; t++) begin
         @(posedge clk); #1;
         if (done16) seen = 1;
         else busy_cycles += int'(busy16);
      end
      if (!seen) chk({nm, " done timeout"}, 0, 1);
   endtask

   task automatic do_cmp(input string nm, input logic [15:0] x, input logic [15:0] y,
                         input logic eq, input logic mo, input logic le, input int sl);
      exp_t e;
      int   bc;
      a16 = x; b16 = y; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      e.eq = eq; e.mo = mo; e.le = le; e.sl = sl; e.acc = cyc;
      q16.push_back(e);
      wait_done16(nm, bc);
      chk({nm, " busy cycles"}, bc, sl);
      chk({nm, " busy after done"}, int'(busy16), 0);
   endtask

   task automatic sweep(input int w, input int n);
      int          nsl = w / 4;
      logic [31:0] x, y, msk;
      exp_t        e;
      bit          seen;
      msk = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 1);
      for (int i = 0; i < n; i++) begin
         x = $urandom;
         case ($urandom_range(0, 2))
            0: y = $urandom;
            1: y = x;
            default: y = x ^ (32'($urandom_range(1, 15)) << (4 * $urandom_range(0, nsl - 1)));
         endcase
         x &= msk;
         y &= msk;
         e = model(x, y, nsl);
         if (w == 8) begin a8 = 8'(x); b8 = 8'(y); start8 = 1'b1; end
         else begin a32 = x; b32 = y; start32 = 1'b1; end
         @(posedge clk); #1;
         start8 = 1'b0; start32 = 1'b0;
         e.acc = cyc;
         if (w == 8) q8.push_back(e); else q32.push_back(e);
         seen = 0;
         for (int t = 0; t < nsl + 3 && !seen; t++) begin
            @(posedge clk); #1;
            seen = (w == 8) ? done8 : done32;
         end
         if (!seen) chk($sformatf("w%0d done timeout", w), 0, 1);
      end
   endtask

   initial begin
      exp_t e;
      int   bc;
      #1;
      chk("reset busy", int'(busy16), 0);
      chk("reset done", int'(done16), 0);
      chk("reset flags", int'({eq16, mo16, le16}), 0);
      chk("reset slices", int'(sl16), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      do_cmp("eq 1234", 16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0, 4);
      do_cmp("msb 8000", 16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1);
      repeat (3) @(posedge clk); #1;
      chk("flags hold more", int'(mo16), 1);
      chk("flags hold slices", int'(sl16), 1);
      do_cmp("mid 12F4", 16'h12F4, 16'h1234, 1'b0, 1'b1, 1'b0, 3);
      do_cmp("lsb 0001", 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1, 4);

      // start held through CMP with operands changed; second request lands on done-cycle edge
      a16 = 16'h1234; b16 = 16'h1234; start16 = 1'b1;
      @(posedge clk); #1;
      e.eq = 1'b1; e.mo = 1'b0; e.le = 1'b0; e.sl = 4; e.acc = cyc;
      q16.push_back(e);
      a16 = 16'hFFFF; b16 = 16'h0000;
      wait_done16("hold start first", bc);
      @(posedge clk); #1;
      start16 = 1'b0;
      e.eq = 1'b0; e.mo = 1'b1; e.le = 1'b0; e.sl = 1; e.acc = cyc;
      q16.push_back(e);
      chk("b2b busy", int'(busy16), 1);
      chk("b2b cleared", int'({eq16, mo16, le16}), 0);
      wait_done16("hold start second", bc);

      // Reset mid-operation: outputs clear asynchronously and no done follows
      a16 = 16'hAAAA; b16 = 16'hAAAA; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst busy", int'(busy16), 0);
      chk("midrst done", int'(done16), 0);
      chk("midrst flags", int'({eq16, mo16, le16}), 0);
      chk("midrst slices", int'(sl16), 0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (6) @(posedge clk); #1;
      chk("midrst idle", int'(busy16), 0);
      do_cmp("post rst", 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b1, 4);

      sweep(8, 1000);
      sweep(32, 1000);
      repeat (3) @(posedge clk); #1;
      chk("w16 queue drained", q16.size(), 0);
      chk("w8 queue drained", q8.size(), 0);
      chk("w32 queue drained", q32.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
